am2302_ctrl: RTL and testbench

AM2302_CTRL -- requirements
Module: am2302_ctrl

---
 rtl/am2302_pkg.sv | 31 +++
 rtl/am2302_tick_gen.sv | 40 ++++
 rtl/am2302_ctrl.sv | 143 ++++++++++++++
 tb/tb_am2302_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/am2302_pkg.sv
// Shared definitions for the AM2302 single-wire humidity/temperature controller:
// default timing, FSM state encoding and the frame checksum rule.
package am2302_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF   = 100_000_000;
  localparam int unsigned START_LOW_US_DEF  = 1000;
  localparam int unsigned HOLDOFF_MS_DEF    = 2000;
  localparam int unsigned TIMEOUT_US_DEF    = 200;
  localparam int unsigned BIT_THRESH_US_DEF = 40;
  localparam int unsigned FRAME_BITS        = 40;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_HOLDOFF   = 4'd8
  } state_t;

  // Byte 4 must equal the 8-bit wrapping sum of bytes 0..3.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/am2302_tick_gen.sv
// Microsecond and millisecond strobes derived from the system clock; clr
// realigns both dividers so a state's first tick is a full period after entry.
module am2302_tick_gen
  import am2302_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clr,
  output logic us_tick,
  output logic ms_tick
);

  localparam int unsigned US_DIV = (CLK_FREQ_HZ >= 1_000_000) ? CLK_FREQ_HZ / 1_000_000 : 1;

  logic [31:0] div_cnt;
  logic [9:0]  us_in_ms;
  logic        at_us;

  assign at_us   = (div_cnt == 32'(US_DIV - 1));
  assign us_tick = at_us && !clr;
  assign ms_tick = us_tick && (us_in_ms == 10'd999);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_cnt  <= '0;
      us_in_ms <= '0;
    end else if (clr) begin
      div_cnt  <= '0;
      us_in_ms <= '0;
    end else if (at_us) begin
      div_cnt  <= '0;
      us_in_ms <= (us_in_ms == 10'd999) ? '0 : us_in_ms + 10'd1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/am2302_ctrl.sv
// AM2302 bus controller: issues the start pulse, decodes the 40-bit reply,
// checks it and enforces the sensor holdoff between measurements.
module am2302_ctrl
  import am2302_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = CLK_FREQ_HZ_DEF,
  parameter int unsigned START_LOW_US  = START_LOW_US_DEF,
  parameter int unsigned HOLDOFF_MS    = HOLDOFF_MS_DEF,
  parameter int unsigned TIMEOUT_US    = TIMEOUT_US_DEF,
  parameter int unsigned BIT_THRESH_US = BIT_THRESH_US_DEF
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic        auto_en,
  input  logic        dq_i,
  output logic        dq_oe,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        err_crc,
  output logic        err_timeout
);

  state_t      state, nxt;
  logic        tick_clr, us_tick, ms_tick;
  logic [15:0] us_cnt, ms_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] frame;
  logic        pending;
  logic        dq_meta, dq_s, dq_prev;
  logic        dq_fall, dq_rise, bus_wait, timeout, last_bit;

  am2302_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .clr     (tick_clr),
    .us_tick (us_tick),
    .ms_tick (ms_tick)
  );

  // Idle-high bus: synchronizer resets to 1 so release of reset is not an edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      dq_meta <= 1'b1;
      dq_s    <= 1'b1;
      dq_prev <= 1'b1;
    end else begin
      dq_meta <= dq_i;
      dq_s    <= dq_meta;
      dq_prev <= dq_s;
    end
  end

  assign dq_fall  = dq_prev & ~dq_s;
  assign dq_rise  = ~dq_prev & dq_s;
  assign dq_oe    = (state == S_START_LOW);
  assign busy     = (state != S_IDLE);
  assign bus_wait = (state inside {S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH});
  assign timeout  = bus_wait && us_tick && (us_cnt == 16'(TIMEOUT_US - 1));
  assign last_bit = (bit_cnt == 6'(FRAME_BITS - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (start || auto_en) nxt = S_START_LOW;
      S_START_LOW: if (us_tick && us_cnt == 16'(START_LOW_US - 1)) nxt = S_RELEASE;
      S_RELEASE:   if (dq_fall) nxt = S_RESP_LOW;
      S_RESP_LOW:  if (dq_rise) nxt = S_RESP_HIGH;
      S_RESP_HIGH: if (dq_fall) nxt = S_BIT_LOW;
      S_BIT_LOW:   if (dq_rise) nxt = S_BIT_HIGH;
      S_BIT_HIGH:  if (dq_fall) nxt = last_bit ? S_CHECK : S_BIT_LOW;
      S_CHECK:     nxt = S_HOLDOFF;
      S_HOLDOFF:
        if (ms_tick && ms_cnt == 16'(HOLDOFF_MS - 1))
          nxt = (auto_en || pending || start) ? S_START_LOW : S_IDLE;
      default:     nxt = S_IDLE;
    endcase
    if (timeout) nxt = S_HOLDOFF;
  end

  // Every state change restarts both the local counters and the tick dividers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= S_IDLE;
      tick_clr    <= 1'b0;
      us_cnt      <= '0;
      ms_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      pending     <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      err_crc     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state    <= nxt;
      tick_clr <= (nxt != state);
      done     <= 1'b0;

      if (nxt != state) begin
        us_cnt <= '0;
        ms_cnt <= '0;
      end else begin
        if (us_tick) us_cnt <= us_cnt + 16'd1;
        if (ms_tick) ms_cnt <= ms_cnt + 16'd1;
      end

      if (nxt == S_START_LOW && state != S_START_LOW) begin
        err_crc     <= 1'b0;
        err_timeout <= 1'b0;
        bit_cnt     <= '0;
        pending     <= 1'b0;
      end else if (start && nxt == S_HOLDOFF && (state == S_HOLDOFF || timeout)) begin
        pending <= 1'b1;
      end

      if (timeout) begin
        err_timeout <= 1'b1;
        done        <= 1'b1;
      end else if (state == S_BIT_HIGH && dq_fall) begin
        frame   <= {frame[38:0], (us_cnt > 16'(BIT_THRESH_US))};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (state == S_CHECK) begin
        done <= 1'b1;
        if (checksum_ok(frame)) begin
          humidity    <= frame[39:24];
          temperature <= frame[23:8];
          valid       <= 1'b1;
        end else begin
          err_crc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_am2302_ctrl.sv
// Bench for am2302_ctrl at 1 MHz: behavioural AM2302 sensor, scoreboard of
// expected measurement results, and timing checks on the bus and holdoff.
`timescale 1ns/1ps
module tb_am2302_ctrl;

  localparam time US = 1000;

  typedef struct {
    logic        crc;
    logic        tmo;
    logic        vld;
    logic [15:0] hum;
    logic [15:0] temp;
  } exp_t;

  logic        ACLK, ARESET, start, auto_en, dq_i;
  logic        dq_oe, busy, done, valid, err_crc, err_timeout;
  logic [15:0] humidity, temperature;
  logic        sens_low;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          oe_rises = 0;
  time         done_time, oe_rise_t, oe_fall_t;

  exp_t        exp_q[$];
  logic [39:0] frames[$];

  logic        m_valid = 1'b0;
  logic [15:0] m_hum = '0, m_temp = '0;

  am2302_ctrl #(.CLK_FREQ_HZ(1_000_000), .HOLDOFF_MS(2)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .start       (start),
    .auto_en     (auto_en),
    .dq_i        (dq_i),
    .dq_oe       (dq_oe),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .humidity    (humidity),
    .temperature (temperature),
    .err_crc     (err_crc),
    .err_timeout (err_timeout)
  );

  assign dq_i = ~(dq_oe | sens_low);

  initial begin
    ACLK = 1'b0;
    forever #500 ACLK = ~ACLK;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a read succeeds iff byte4 == (b0+b1+b2+b3) mod 256; a good
  // read replaces the held words, a bad one leaves them.
  task automatic expect_read(input logic [39:0] f);
    int   sum;
    bit   ok;
    exp_t e;
    sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    ok  = (sum % 256) == int'(f[7:0]);
    if (ok) begin
      m_valid = 1'b1;
      m_hum   = f[39:24];
      m_temp  = f[23:8];
    end
    e.crc = !ok; e.tmo = 1'b0; e.vld = m_valid; e.hum = m_hum; e.temp = m_temp;
    exp_q.push_back(e);
  endtask

  task automatic expect_timeout();
    exp_t e;
    e.crc = 1'b0; e.tmo = 1'b1; e.vld = m_valid; e.hum = m_hum; e.temp = m_temp;
    exp_q.push_back(e);
  endtask

  function automatic logic [39:0] rand_frame();
    logic [31:0] d;
    int          sum;
    logic [7:0]  c;
    d   = $urandom;
    sum = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    c   = 8'(sum % 256);
    if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
    return {d, c};
  endfunction

  // Sensor: after each host start pulse, answer with the next queued frame.
  initial begin
    logic [39:0] f;
    sens_low = 1'b0;
    forever begin
      @(posedge dq_oe);
      @(negedge dq_oe);
      if (frames.size() != 0) begin
        f = frames.pop_front();
        #(US * 30 + 100);
        sens_low = 1'b1; #(US * 80);
        sens_low = 1'b0; #(US * 80);
        for (int i = 39; i >= 0; i--) begin
          sens_low = 1'b1; #(US * 50);
          sens_low = 1'b0;
          if (f[i]) #(US * 70); else #(US * 26);
        end
        sens_low = 1'b1; #(US * 50);
        sens_low = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge dq_oe);
    oe_rises++;
    oe_rise_t = $time;
  end

  initial forever begin
    @(negedge dq_oe);
    oe_fall_t = $time;
  end

  // Scoreboard monitor.
  initial forever begin
    exp_t e;
    @(negedge ACLK);
    if (!ARESET && done) begin
      done_cnt++;
      done_time = $time;
      chk("sb_done_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("err_crc", err_crc, e.crc);
        chk("err_timeout", err_timeout, e.tmo);
        chk("valid", valid, e.vld);
        chk("humidity", humidity, e.hum);
        chk("temperature", temperature, e.temp);
      end
    end
  end

  initial begin
    #(US * 150_000);
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge ACLK) start = 1'b1;
    @(negedge ACLK) start = 1'b0;
  endtask

  task automatic do_start();
    pulse_start();
    chk("start_low_entered", dq_oe, 1'b1);
  endtask

  task automatic wait_done(input int n, input int limit);
    for (int i = 0; i < limit && done_cnt == n; i++) @(negedge ACLK);
    chk("done_arrives", done_cnt != n, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge ACLK);
    chk("reach_idle", busy, 1'b0);
  endtask

  task automatic chk_start_low_width();
    int w;
    w = int'((oe_fall_t - oe_rise_t) / US);
    chk("start_low_us_in_999_1002", (w >= 999 && w <= 1002), 1'b1);
  endtask

  initial begin
    logic [39:0] f;
    int n, r0, w, lows;
    ARESET = 1'b1; start = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", {dq_oe, busy, done, valid, err_crc, err_timeout, humidity, temperature}, '0);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);

    // Good fixed frame.
    f = 40'h02_8C_01_5F_EE;
    frames.push_back(f); expect_read(f);
    n = done_cnt; do_start(); wait_done(n, 8000);
    chk_start_low_width();
    wait_idle(2500);

    // Bad checksum keeps previous words.
    f = 40'h02_8C_01_5F_EF;
    frames.push_back(f); expect_read(f);
    n = done_cnt; do_start(); wait_done(n, 8000);
    wait_idle(2500);

    // Silent sensor -> timeout, busy through holdoff.
    expect_timeout();
    n = done_cnt; do_start(); wait_done(n, 2000);
    chk_start_low_width();
    w = int'((done_time - oe_fall_t) / US);
    chk("timeout_delay_us_in_199_203", (w >= 199 && w <= 203), 1'b1);
    lows = 0;
    for (int i = 0; i < 1900; i++) begin
      @(negedge ACLK);
      if (!busy) lows++;
    end
    chk("busy_low_cycles_in_holdoff", lows, 0);
    wait_idle(500);

    // Random read with an ignored mid-transfer start.
    f = rand_frame();
    frames.push_back(f); expect_read(f);
    r0 = oe_rises;
    n = done_cnt; do_start();
    repeat (2500) @(negedge ACLK);
    pulse_start();
    wait_done(n, 6000);
    wait_idle(2500);
    chk("start_pulses_after_ignored_start", oe_rises - r0, 1);

    // Random read, then a start 100 us after done is held off.
    f = rand_frame();
    frames.push_back(f); expect_read(f);
    n = done_cnt; do_start(); wait_done(n, 8000);
    repeat (100) @(negedge ACLK);
    f = rand_frame();
    frames.push_back(f); expect_read(f);
    n = done_cnt; r0 = oe_rises;
    pulse_start();
    for (int i = 0; i < 2500 && oe_rises == r0; i++) @(negedge ACLK);
    w = int'((oe_rise_t - done_time) / US);
    chk("holdoff_start_us_in_1998_2005", (oe_rises != r0 && w >= 1998 && w <= 2005), 1'b1);
    wait_done(n, 7000);
    wait_idle(2500);

    // Asynchronous reset 300 us into the start pulse.
    n = done_cnt; do_start();
    repeat (300) @(posedge ACLK);
    #200 ARESET = 1'b1;
    #1;
    chk("async_reset_outputs", {dq_oe, busy, done, valid, err_crc, err_timeout, humidity, temperature}, '0);
    m_valid = 1'b0; m_hum = '0; m_temp = '0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);
    chk("no_done_from_aborted_read", done_cnt - n, 0);
    f = 40'h02_8C_01_5F_EE;
    frames.push_back(f); expect_read(f);
    n = done_cnt; do_start(); wait_done(n, 8000);
    chk_start_low_width();
    wait_idle(2500);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
